// File: rtl/charge_arbiter.sv
// -----------------------------------------------------------------------------
// charge_arbiter
//
// Purpose:
//   Round-robin arbiter that funnels charge packets from NUM_REQ requesters
//   into a single registered output slot feeding a neuron input link. While
//   the slot is stalled (neuron_rdy low), a request that targets the same
//   neuron address is merged into the held charge with 16-bit signed
//   saturation rather than waiting for the slot to drain.
//
// Ports:
//   clk           in   single clock; all state updates on the rising edge
//   reset         in   synchronous active-high reset, highest priority
//   enable        in   low blocks new grants; a held slot still drains
//   clear_act     in   synchronous flush of held charge, pointer and counter
//   req_addr      in   NUM_REQ x 8-bit target addresses, lane i at [8i+7:8i]
//   req_charge    in   NUM_REQ x 16-bit signed charges, lane i at [16i+15:16i]
//   req_vld       in   NUM_REQ request valids
//   req_rdy       out  one-hot grant, combinational, only in the grant cycle
//   neuron_addr   out  registered slot address
//   neuron_charge out  registered slot charge (signed)
//   neuron_vld    out  registered slot valid
//   neuron_rdy    in   downstream ready; transfer when vld && rdy
//   merge_count   out  merges since reset/flush, saturating at 65535
//   idle          out  no held item and no pending request
// -----------------------------------------------------------------------------
module charge_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear_act,
  input  logic [NUM_REQ*8-1:0]      req_addr,
  input  logic [NUM_REQ*16-1:0]     req_charge,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [7:0]                neuron_addr,
  output logic signed [15:0]        neuron_charge,
  output logic                      neuron_vld,
  input  logic                      neuron_rdy,
  output logic [15:0]               merge_count,
  output logic                      idle
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Lane reached by stepping 'off' places from 'base', wrapping at NUM_REQ.
  // Works for non-power-of-two lane counts, so a plain bit truncation is not
  // enough.
  function automatic logic [PTR_W-1:0] lane_at(input logic [PTR_W-1:0] base,
                                                input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Signed 16-bit add evaluated in 17 bits; when the two top bits disagree the
  // true result left the 16-bit range and is clamped toward its sign.
  function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [16:0] sum;
    logic signed [15:0] res;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) begin
      res = sum[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      res = sum[15:0];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]         out_addr_q,    out_addr_d;
  logic signed [15:0] out_charge_q,  out_charge_d;
  logic               out_vld_q,     out_vld_d;
  logic [PTR_W-1:0]   ptr_q,         ptr_d;
  logic [15:0]        merge_count_q, merge_count_d;

  // ---------------------------------------------------------------------------
  // Lane unpacking and winner search
  // ---------------------------------------------------------------------------
  logic [7:0]         lane_addr_s   [NUM_REQ];
  logic signed [15:0] lane_charge_s [NUM_REQ];
  logic [PTR_W-1:0]   cand_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic               win_found_s;
  logic [7:0]         win_addr_s;
  logic signed [15:0] win_charge_s;

  // Split the flat request buses into per-lane fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_addr_s[i]   = req_addr[8*i +: 8];
      lane_charge_s[i] = req_charge[16*i +: 16];
    end
  end

  // First valid lane searching ptr, ptr+1, ... with wrap-around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = lane_at(ptr_q, k);
      if (!win_found_s && req_vld[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_addr_s   = lane_addr_s[win_idx_s];
  assign win_charge_s = lane_charge_s[win_idx_s];

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic slot_free_s;
  logic merge_ok_s;
  logic grant_s;

  // slot_free and merge_ok are mutually exclusive (one needs ~out_vld or
  // neuron_rdy, the other out_vld and ~neuron_rdy), so a transfer cycle with a
  // matching address always reloads rather than merges.
  assign slot_free_s = ~out_vld_q | neuron_rdy;
  assign merge_ok_s  = out_vld_q & ~neuron_rdy & (win_addr_s == out_addr_q);
  assign grant_s     = enable & ~clear_act & ~reset & win_found_s &
                       (slot_free_s | merge_ok_s);

  // One-hot ready to the granted lane only.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s && (win_idx_s == PTR_W'(i))) begin
        req_rdy[i] = 1'b1;
      end else begin
        req_rdy[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------

  // Slot, pointer and merge counter update; flush beats grant and transfer.
  // Reset is applied in the register process and already masks grant_s.
  always_comb begin
    out_addr_d    = out_addr_q;
    out_charge_d  = out_charge_q;
    out_vld_d     = out_vld_q;
    ptr_d         = ptr_q;
    merge_count_d = merge_count_q;
    if (clear_act) begin
      out_vld_d     = 1'b0;
      ptr_d         = '0;
      merge_count_d = 16'd0;
    end else if (grant_s) begin
      ptr_d = (win_idx_s == LAST_LANE) ? '0 : win_idx_s + PTR_W'(1);
      if (slot_free_s) begin
        out_addr_d   = win_addr_s;
        out_charge_d = win_charge_s;
        out_vld_d    = 1'b1;
      end else begin
        out_charge_d  = sat_add16(out_charge_q, win_charge_s);
        merge_count_d = (merge_count_q == 16'hffff) ? merge_count_q
                                                     : merge_count_q + 16'd1;
      end
    end else if (out_vld_q && neuron_rdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr_q    <= 8'd0;
      out_charge_q  <= 16'sd0;
      out_vld_q     <= 1'b0;
      ptr_q         <= '0;
      merge_count_q <= 16'd0;
    end else begin
      out_addr_q    <= out_addr_d;
      out_charge_q  <= out_charge_d;
      out_vld_q     <= out_vld_d;
      ptr_q         <= ptr_d;
      merge_count_q <= merge_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign neuron_addr   = out_addr_q;
  assign neuron_charge = out_charge_q;
  assign neuron_vld    = out_vld_q;
  assign merge_count   = merge_count_q;
  assign idle          = ~out_vld_q & ~|req_vld;

endmodule

// File: tb/tb_charge_arbiter.sv
// Bench for charge_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked against a cycle-level behavioural model.
module tb_charge_arbiter;

  localparam int N = 4;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               clear_act;
  logic [N*8-1:0]     req_addr;
  logic [N*16-1:0]    req_charge;
  logic [N-1:0]       req_vld;
  logic [N-1:0]       req_rdy;
  logic [7:0]         neuron_addr;
  logic signed [15:0] neuron_charge;
  logic               neuron_vld;
  logic               neuron_rdy;
  logic [15:0]        merge_count;
  logic               idle;

  charge_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear_act     (clear_act),
    .req_addr      (req_addr),
    .req_charge    (req_charge),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .neuron_addr   (neuron_addr),
    .neuron_charge (neuron_charge),
    .neuron_vld    (neuron_vld),
    .neuron_rdy    (neuron_rdy),
    .merge_count   (merge_count),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the slot and arbitration state.
  bit m_init = 1'b0;   // a reset edge has been seen
  bit m_def  = 1'b0;   // addr/charge have a defined expected value
  bit m_vld  = 1'b0;
  int m_addr = 0;
  int m_charge = 0;
  int m_ptr = 0;
  int m_merge = 0;
  int rdy_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane_addr(input int l);
    return int'(req_addr[8*l +: 8]);
  endfunction

  function automatic int lane_charge(input int l);
    logic signed [15:0] c;
    c = req_charge[16*l +: 16];
    return int'(c);
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_grant(input int w);
    if (!enable || clear_act || reset || w < 0) return 1'b0;
    if (!m_vld || neuron_rdy) return 1'b1;
    return lane_addr(w) == m_addr;
  endfunction

  task automatic check_comb();
    int w;
    int exp_rdy;
    w = model_winner();
    exp_rdy = model_grant(w) ? (1 << w) : 0;
    chk("req_rdy", int'(req_rdy), exp_rdy);
    if (m_init) chk("idle", int'(idle), int'(!m_vld && req_vld == '0));
    rdy_seen = int'(req_rdy);
  endtask

  task automatic model_update();
    int w;
    int s;
    w = model_winner();
    if (reset) begin
      m_init = 1'b1; m_def = 1'b1; m_vld = 1'b0;
      m_addr = 0; m_charge = 0; m_ptr = 0; m_merge = 0;
    end else if (clear_act) begin
      m_vld = 1'b0; m_def = 1'b0; m_ptr = 0; m_merge = 0;
    end else if (model_grant(w)) begin
      m_ptr = (w + 1) % N;
      if (!m_vld || neuron_rdy) begin
        m_vld = 1'b1; m_def = 1'b1;
        m_addr = lane_addr(w); m_charge = lane_charge(w);
      end else begin
        s = m_charge + lane_charge(w);
        m_charge = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        m_merge = (m_merge < 65535) ? m_merge + 1 : 65535;
      end
    end else if (m_vld && neuron_rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check_regs();
    if (!m_init) return;
    chk("neuron_vld", int'(neuron_vld), int'(m_vld));
    chk("merge_count", int'(merge_count), m_merge);
    if (m_def) begin
      chk("neuron_addr", int'(neuron_addr), m_addr);
      chk("neuron_charge", int'(neuron_charge), m_charge);
    end
  endtask

  // One clock: inputs are already set just after a falling edge.
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_lane(input int l, input logic v, input logic [7:0] a,
                          input logic [15:0] c);
    req_vld[l] = v;
    req_addr[8*l +: 8] = a;
    req_charge[16*l +: 16] = c;
  endtask

  task automatic clear_lanes();
    req_vld = '0;
    req_addr = '0;
    req_charge = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_lanes();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear_act = 1'b0; neuron_rdy = 1'b0;
    clear_lanes();
    @(negedge clk);

    // Reset values
    do_reset();
    step();
    chk("rst_vld", int'(neuron_vld), 0);
    chk("rst_addr", int'(neuron_addr), 0);
    chk("rst_charge", int'(neuron_charge), 0);
    chk("rst_merge", int'(merge_count), 0);
    chk("rst_idle", int'(idle), 1);

    // Round robin over four distinct addresses
    do_reset();
    neuron_rdy = 1'b1;
    for (int l = 0; l < N; l++) set_lane(l, 1'b1, 8'(10 + l), 16'(l + 1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", rdy_seen, 1 << (i % N));
      chk("rr_addr", int'(neuron_addr), 10 + (i % N));
    end

    // Merge: {5,+100} then {5,-30} while stalled
    do_reset();
    neuron_rdy = 1'b0;
    set_lane(0, 1'b1, 8'd5, 16'd100);
    step();
    chk("mrg_first", rdy_seen, 1);
    set_lane(0, 1'b0, 8'd0, 16'd0);
    set_lane(2, 1'b1, 8'd5, -16'sd30);
    step();
    chk("mrg_rdy2", rdy_seen, 4);
    chk("mrg_charge", int'(neuron_charge), 70);
    chk("mrg_count", int'(merge_count), 1);

    // No merge on a different address, then transfer + load together
    set_lane(2, 1'b0, 8'd0, 16'd0);
    set_lane(1, 1'b1, 8'd6, 16'd40);
    step();
    chk("nomrg_rdy", rdy_seen, 0);
    chk("nomrg_hold", int'(neuron_charge), 70);
    neuron_rdy = 1'b1;
    step();
    chk("xfer_rdy", rdy_seen, 2);
    chk("xfer_addr", int'(neuron_addr), 6);
    chk("xfer_charge", int'(neuron_charge), 40);

    // Positive and negative saturation
    do_reset();
    neuron_rdy = 1'b0;
    set_lane(0, 1'b1, 8'd9, 16'd32000);
    step();
    set_lane(0, 1'b0, 8'd0, 16'd0);
    set_lane(1, 1'b1, 8'd9, 16'd1000);
    step();
    chk("sat_pos", int'(neuron_charge), 32767);
    do_reset();
    set_lane(0, 1'b1, 8'd9, -16'sd32000);
    step();
    set_lane(0, 1'b0, 8'd0, 16'd0);
    set_lane(1, 1'b1, 8'd9, -16'sd1000);
    step();
    chk("sat_neg", int'(neuron_charge), -32768);

    // Flush mid-stall, then lane 0 wins first
    do_reset();
    set_lane(1, 1'b1, 8'd7, 16'd1);
    step();
    set_lane(1, 1'b0, 8'd0, 16'd0);
    set_lane(2, 1'b1, 8'd7, 16'd5);
    step();
    chk("fl_premerge", int'(merge_count), 1);
    for (int l = 0; l < N; l++) set_lane(l, 1'b1, 8'd7, 16'd2);
    clear_act = 1'b1;
    step();
    chk("fl_rdy", rdy_seen, 0);
    chk("fl_vld", int'(neuron_vld), 0);
    chk("fl_merge", int'(merge_count), 0);
    clear_act = 1'b0;
    step();
    chk("fl_lane0", rdy_seen, 1);

    // Enable low: held item drains, no grants
    do_reset();
    set_lane(0, 1'b1, 8'd3, 16'd3);
    step();
    enable = 1'b0;
    for (int l = 0; l < N; l++) set_lane(l, 1'b1, 8'(20 + l), 16'd1);
    step();
    chk("en_stall_rdy", rdy_seen, 0);
    neuron_rdy = 1'b1;
    step();
    chk("en_drain_rdy", rdy_seen, 0);
    chk("en_drained", int'(neuron_vld), 0);
    enable = 1'b1;
    step();
    chk("en_resume", rdy_seen, 2);

    // Reset mid-stall
    neuron_rdy = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rs_rdy", rdy_seen, 0);
    chk("rs_vld", int'(neuron_vld), 0);
    chk("rs_addr", int'(neuron_addr), 0);
    chk("rs_charge", int'(neuron_charge), 0);
    reset = 1'b0;

    // Randomized traffic with small address space to force merges
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      clear_act  = ($urandom_range(0, 39) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      neuron_rdy = ($urandom_range(0, 2) == 0);
      for (int l = 0; l < N; l++) begin
        set_lane(l, ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 2)),
                 16'($urandom_range(0, 65535)));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
